score_display_driver: RTL and testbench

Drives the Basys3 four-digit seven-segment display from the binary game score. Converts a 14-bit score to four BCD digits with a sequential shift-add-3 (double-dabble) engine, then time-multiplexes the anodes. Presents one BCD nibble at a time on `digit` for the per-digit segment decoder. Sits between the scoring logic and the segment decoder / board pins.

---
 rtl/score_display_driver.sv | 142 ++++++++++++++
 tb/tb_score_display_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// score_display_driver: binary score -> BCD via sequential double-dabble,
// then time-multiplexed onto the Basys3 four-digit seven-segment anodes.
// The displayed value is only replaced when a conversion finishes, so the
// scan never shows a half-converted number.
module score_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] score_in,
   input  logic        score_valid,
   output logic        busy,
   output logic [3:0]  digit,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int              CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]   REF_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [13:0]     SCORE_MAX  = 14'd9999;
   localparam logic [3:0]      LAST_SHIFT = 4'd13;

   typedef enum logic {IDLE, CONV} state_t;

   state_t        state_q, state_d;
   logic [13:0]   work_bin_q, work_bin_d;
   logic [15:0]   work_bcd_q, work_bcd_d;
   logic [3:0]    iter_q, iter_d;
   logic [15:0]   disp_bcd_q, disp_bcd_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] ref_cnt_q, ref_cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    digit_q, digit_d;
   logic [3:0]    an_q, an_d;

   logic [15:0]   adj_bcd;
   logic [29:0]   shifted;
   logic          upper_zero;
   logic          blank;

   // Double-dabble step: add 3 to nibbles >= 5, then shift the joined
   // {bcd, bin} register left one bit. Fourteen steps cover all 14 input bits.
   always_comb begin
      adj_bcd = work_bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (work_bcd_q[4*i +: 4] >= 4'd5)
            adj_bcd[4*i +: 4] = work_bcd_q[4*i +: 4] + 4'd3;
      end
      shifted = {adj_bcd, work_bin_q} << 1;
   end

   // Conversion FSM next state; a load strobe while converting is dropped.
   always_comb begin
      state_d    = state_q;
      work_bin_d = work_bin_q;
      work_bcd_d = work_bcd_q;
      iter_d     = iter_q;
      disp_bcd_d = disp_bcd_q;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (score_valid) begin
               work_bin_d = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;
               work_bcd_d = 16'h0000;
               iter_d     = 4'd0;
               busy_d     = 1'b1;
               state_d    = CONV;
            end
         end
         CONV: begin
            work_bcd_d = shifted[29:14];
            work_bin_d = shifted[13:0];
            iter_d     = iter_q + 4'd1;
            if (iter_q == LAST_SHIFT) begin
               disp_bcd_d = shifted[29:14];
               busy_d     = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running refresh divider; each wrap moves the scan to the next slot.
   always_comb begin
      ref_cnt_d = ref_cnt_q + CW'(1);
      sel_d     = sel_q;
      if (ref_cnt_q == REF_LAST) begin
         ref_cnt_d = '0;
         sel_d     = sel_q + 2'd1;
      end
   end

   // Slot outputs; a slot above the units is blanked when it and every
   // higher digit are zero (leading zero).
   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(sel_q) && disp_bcd_q[4*i +: 4] != 4'd0)
            upper_zero = 1'b0;
      end
      blank   = BLANK_LZ && (sel_q != 2'd0) && upper_zero;
      digit_d = disp_bcd_q[4*sel_q +: 4];
      an_d    = 4'b1111;
      if (!blank)
         an_d[sel_q] = 1'b0;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         work_bin_q <= '0;
         work_bcd_q <= '0;
         iter_q     <= '0;
         disp_bcd_q <= '0;
         busy_q     <= 1'b0;
         ref_cnt_q  <= '0;
         sel_q      <= '0;
         digit_q    <= '0;
         an_q       <= 4'b1110;
      end else begin
         state_q    <= state_d;
         work_bin_q <= work_bin_d;
         work_bcd_q <= work_bcd_d;
         iter_q     <= iter_d;
         disp_bcd_q <= disp_bcd_d;
         busy_q     <= busy_d;
         ref_cnt_q  <= ref_cnt_d;
         sel_q      <= sel_d;
         digit_q    <= digit_d;
         an_q       <= an_d;
      end
   end

   assign busy  = busy_q;
   assign digit = digit_q;
   assign an    = an_q;
   assign dp    = 1'b1;

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: two instances (leading-zero blanking on
// and off) share one stimulus stream; every cycle is compared against a
// decimal-arithmetic model of conversion latency and the scan sequence.
module tb_score_display_driver;

   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        score_valid = 1'b0;
   logic [13:0] score_in = '0;
   logic        busy1, dp1, busy0, dp0;
   logic [3:0]  digit1, an1, digit0, an0;

   int checks = 0;
   int errors = 0;

   // model state
   int m_k    = 0;   // clock edges since reset release
   int m_cnt  = 0;   // cycles of conversion remaining
   int m_pend = 0;
   int m_disp = 0;

   score_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut1 (
      .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
      .busy(busy1), .digit(digit1), .an(an1), .dp(dp1));

   score_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
      .busy(busy0), .digit(digit0), .an(an0), .dp(dp0));

   always #5 clk = ~clk;

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [3:0] exp_an(input int disp, input int sel, input bit blz);
      logic [3:0] a;
      a = 4'b1111;
      if (!(blz && sel > 0 && disp < pow10(sel)))
         a[sel] = 1'b0;
      return a;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, m_k);
      end
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input bit r, input bit v, input int s);
      int sel_b, disp_b;
      logic [3:0] e_dig, e_an1, e_an0;
      bit e_busy;
      rst = r; score_valid = v; score_in = s[13:0];
      @(posedge clk);
      if (r) begin
         m_k = 0; m_cnt = 0; m_disp = 0;
         e_dig = 4'd0; e_an1 = 4'b1110; e_an0 = 4'b1110; e_busy = 1'b0;
      end else begin
         sel_b  = (m_k / RD) % 4;
         disp_b = m_disp;
         m_k++;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_disp = m_pend;
         end else if (v) begin
            m_cnt  = 14;
            m_pend = (s > 9999) ? 9999 : s;
         end
         e_busy = (m_cnt > 0);
         e_dig  = 4'((disp_b / pow10(sel_b)) % 10);
         e_an1  = exp_an(disp_b, sel_b, 1'b1);
         e_an0  = exp_an(disp_b, sel_b, 1'b0);
      end
      #1;
      chk("busy",   {3'b0, busy1}, {3'b0, e_busy});
      chk("digit",  digit1, e_dig);
      chk("an",     an1,    e_an1);
      chk("dp",     {3'b0, dp1},   4'd1);
      chk("busy_nb", {3'b0, busy0}, {3'b0, e_busy});
      chk("digit_nb", digit0, e_dig);
      chk("an_nb",  an0,    e_an0);
      chk("dp_nb",  {3'b0, dp0},   4'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 0);
   endtask

   task automatic load(input int s, input int settle);
      step(1'b0, 1'b1, s);
      idle(settle);
   endtask

   initial begin
      // reset and empty scan
      repeat (3) step(1'b1, 1'b0, 0);
      idle(20);
      // basic, clamp, maximum, zero
      load(1234, 32);
      load(12000, 32);
      load(9999, 32);
      load(0, 32);
      // leading-zero blanking (dut0 shows all slots)
      load(7, 32);
      load(1005, 32);
      load(50, 32);
      // busy rejection: second strobe 5 cycles after the first
      step(1'b0, 1'b1, 42);
      idle(4);
      step(1'b0, 1'b1, 99);
      idle(30);
      // reset mid-conversion, then a clean load
      step(1'b0, 1'b1, 8765);
      idle(6);
      repeat (2) step(1'b1, 1'b0, 0);
      idle(5);
      load(321, 32);
      // back-to-back strobe exactly at completion edge is ignored
      step(1'b0, 1'b1, 4321);
      idle(13);
      step(1'b0, 1'b1, 77);
      idle(40);
      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 16383)));
      end
      idle(40);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
